piso_serializer: RTL

// Parallel-in, serial-out stage that sits directly upstream of the 4-bit serial-in shift register.
// - Accepts a WIDTH-bit word over a valid/ready handshake.
// - Drives the word out MSB-first on serial_out, one bit per BIT_PERIOD clocks.
// - Because bits are sent MSB-first and the receiver shifts each new bit in at its LSB, the

---
 rtl/piso_serializer.sv | 101 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out stage, MSB first, valid/ready input
// Holds each bit for BIT_PERIOD clocks and strobes shift_en so a SIPO receiver can sample it.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter int BIT_PERIOD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             word_done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_PERIOD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             accept;
  logic             last_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Outputs decode registered state only, so they take reset values as soon as reset rises.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    busy       = (state_q == SHIFT);
    serial_out = 1'b0;
    shift_en   = 1'b0;
    last_bit   = (bit_cnt_q == BIT_LAST);

    if (state_q == SHIFT) begin
      serial_out = shreg_q[WIDTH-1];
      shift_en   = (div_cnt_q == DIV_LAST);
    end

    word_done = shift_en && last_bit;
    in_ready  = (state_q == IDLE) || word_done;
    accept    = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = in_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!shift_en) begin
          div_cnt_d = div_cnt_q + DW'(1);
        end else if (!last_bit) begin
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BW'(1);
          div_cnt_d = '0;
        end else if (accept) begin
          // Reload on the last bit's strobe keeps the stream gapless.
          shreg_d   = in_data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end else begin
          shreg_d   = '0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
